// File: rtl/lynx_tap_player.sv
// Cassette image playback for lynx48: streams tape memory bytes out as an EAR square wave.
// The wave is a leader tone, then one sync cycle, then the data bits MSB first, then a low tail.
// state  | meaning
// IDLE   | no playback, waiting for image + play
// LEADER | pilot tone, PILOT_CYCLES full cycles
// SYNC   | one full cycle of SYNC_HALF
// FETCH  | one-clock read request for r_addr
// WAITD  | waiting for mem_valid; pulse engine stopped
// BITS   | one full cycle per bit of the shift register
// TAIL   | low output for TAIL_TICKS
// DONE   | finished, waits for rewind
module lynx_tap_player #(
    parameter int AW           = 25,
    parameter int CW           = 12,
    parameter int PILOT_HALF   = 250,
    parameter int PILOT_CYCLES = 768,
    parameter int SYNC_HALF    = 500,
    parameter int ZERO_HALF    = 125,
    parameter int ONE_HALF     = 250,
    parameter int TAIL_TICKS   = 2000
) (
    input  logic          i_clock,
    input  logic          i_reset_osd,
    input  logic          i_ce,
    input  logic          i_tap_ready,
    input  logic [AW-1:0] i_tap_size,
    input  logic          i_play,
    input  logic          i_rewind,
    output logic          o_mem_rd,
    output logic [AW-1:0] o_mem_addr,
    input  logic [7:0]    i_mem_data,
    input  logic          i_mem_valid,
    output logic          o_ear,
    output logic          o_active,
    output logic          o_done
);

    localparam int CYW = $clog2(PILOT_CYCLES) + 1;
    localparam logic [CW-1:0] L_PILOT = CW'(PILOT_HALF - 1);
    localparam logic [CW-1:0] L_SYNC  = CW'(SYNC_HALF - 1);
    localparam logic [CW-1:0] L_ZERO  = CW'(ZERO_HALF - 1);
    localparam logic [CW-1:0] L_ONE   = CW'(ONE_HALF - 1);
    localparam logic [CW-1:0] L_TAIL  = CW'(TAIL_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEADER, S_SYNC, S_FETCH, S_WAITD, S_BITS, S_TAIL, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_ear;
    logic [AW-1:0]   r_size;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_shreg;
    logic [2:0]      r_bitcnt;
    logic [CYW-1:0]  r_cyc;
    logic            r_got;
    logic            r_stale;

    logic            w_abort, w_tick, w_exp, w_start, w_valid_ok, w_have, w_take;
    logic            w_last, w_pilot_last;
    logic [CW-1:0]   w_cur_half, w_nxt_half, w_first_half;

    // tap_ready dropping mid-playback means the image is being replaced: same as rewind
    assign w_abort      = i_rewind | (~i_tap_ready & (r_state != S_IDLE));
    assign w_tick       = i_ce & i_play;
    assign w_exp        = w_tick & (r_cnt == '0);
    assign w_start      = i_tap_ready & i_play & (i_tap_size != '0);
    assign w_valid_ok   = i_mem_valid & ~r_stale;
    assign w_have       = r_got | w_valid_ok;
    assign w_take       = w_valid_ok & ~r_got;
    assign w_last       = (r_addr + AW'(1)) == r_size;
    assign w_pilot_last = r_cyc == CYW'(PILOT_CYCLES - 1);
    assign w_cur_half   = r_shreg[7] ? L_ONE : L_ZERO;
    assign w_nxt_half   = r_shreg[6] ? L_ONE : L_ZERO;
    assign w_first_half = (r_got ? r_shreg[7] : i_mem_data[7]) ? L_ONE : L_ZERO;

    always_ff @(posedge i_clock or negedge i_reset_osd) begin
        if (!i_reset_osd) r_state <= S_IDLE;
        else              r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_start) w_next = S_LEADER;
                S_LEADER: if (w_exp & ~r_ear & w_pilot_last) w_next = S_SYNC;
                S_SYNC:   if (w_exp & ~r_ear) w_next = S_FETCH;
                S_FETCH:  if (i_play) w_next = S_WAITD;
                S_WAITD:  if (i_play & w_have) w_next = S_BITS;
                S_BITS:   if (w_exp & ~r_ear & (r_bitcnt == '0)) w_next = w_last ? S_TAIL : S_FETCH;
                S_TAIL:   if (w_exp) w_next = S_DONE;
                S_DONE:   w_next = S_DONE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_mem_rd   = (r_state == S_FETCH) & i_play;
        o_mem_addr = r_addr;
        o_ear      = r_ear;
        o_active   = (r_state != S_IDLE) & (r_state != S_DONE);
        o_done     = r_state == S_DONE;
    end

    always_ff @(posedge i_clock or negedge i_reset_osd) begin
        if (!i_reset_osd) begin
            r_cnt    <= '0;
            r_ear    <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_cyc    <= '0;
            r_got    <= 1'b0;
            r_stale  <= 1'b0;
        end else if (w_abort) begin
            r_cnt   <= '0;
            r_ear   <= 1'b0;
            r_addr  <= '0;
            r_cyc   <= '0;
            r_got   <= 1'b0;
            // remember a read still in flight so its late completion is dropped
            r_stale <= o_mem_rd | ((r_state == S_WAITD) & ~r_got & ~w_valid_ok)
                     | (r_stale & ~i_mem_valid);
        end else begin
            if (i_mem_valid) r_stale <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_size <= i_tap_size;
                    r_addr <= '0;
                    r_cyc  <= '0;
                    r_ear  <= 1'b1;
                    r_cnt  <= L_PILOT;
                end
                S_LEADER: if (w_exp) begin
                    r_ear <= ~r_ear;
                    if (r_ear) begin
                        r_cnt <= L_PILOT;
                    end else if (w_pilot_last) begin
                        r_cnt <= L_SYNC;
                    end else begin
                        r_cnt <= L_PILOT;
                        r_cyc <= r_cyc + CYW'(1);
                    end
                end else if (w_tick) begin
                    r_cnt <= r_cnt - CW'(1);
                end
                S_SYNC: if (w_exp) begin
                    r_ear <= 1'b0;
                    r_cnt <= L_SYNC;
                end else if (w_tick) begin
                    r_cnt <= r_cnt - CW'(1);
                end
                S_WAITD: begin
                    if (w_take) begin
                        r_shreg  <= i_mem_data;
                        r_got    <= 1'b1;
                        r_bitcnt <= 3'd7;
                    end
                    if (i_play & w_have) begin
                        r_got <= 1'b0;
                        r_ear <= 1'b1;
                        r_cnt <= w_first_half;
                    end
                end
                S_BITS: if (w_exp) begin
                    if (r_ear) begin
                        r_ear <= 1'b0;
                        r_cnt <= w_cur_half;
                    end else if (r_bitcnt != '0) begin
                        r_shreg  <= {r_shreg[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt - 3'd1;
                        r_ear    <= 1'b1;
                        r_cnt    <= w_nxt_half;
                    end else if (w_last) begin
                        r_cnt <= L_TAIL;
                    end else begin
                        r_addr <= r_addr + AW'(1);
                    end
                end else if (w_tick) begin
                    r_cnt <= r_cnt - CW'(1);
                end
                S_TAIL: if (w_tick & ~w_exp) r_cnt <= r_cnt - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lynx_tap_player.sv
// Bench for lynx_tap_player: random images and latencies checked against a run-length model
// of the ear waveform (in counted ce ticks) plus a read-address scoreboard.
module tb_lynx_tap_player;
    localparam int AW = 25;
    localparam int CW = 12;
    localparam int PH = 6;
    localparam int PC = 4;
    localparam int SH = 9;
    localparam int ZH = 3;
    localparam int OH = 5;
    localparam int TT = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          tap_ready = 1'b0;
    logic [AW-1:0] tap_size = '0;
    logic          play = 1'b0;
    logic          rewind = 1'b0;
    logic [7:0]    mem_data = '0;
    logic          mem_valid = 1'b0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          ear, active, done;

    lynx_tap_player #(
        .AW(AW), .CW(CW), .PILOT_HALF(PH), .PILOT_CYCLES(PC), .SYNC_HALF(SH),
        .ZERO_HALF(ZH), .ONE_HALF(OH), .TAIL_TICKS(TT)
    ) dut (
        .i_clock(clk), .i_reset_osd(rst_n), .i_ce(ce), .i_tap_ready(tap_ready),
        .i_tap_size(tap_size), .i_play(play), .i_rewind(rewind), .o_mem_rd(mem_rd),
        .o_mem_addr(mem_addr), .i_mem_data(mem_data), .i_mem_valid(mem_valid),
        .o_ear(ear), .o_active(active), .o_done(done)
    );

    always #5 clk = ~clk;

    typedef struct { bit lvl; int len; } run_t;
    run_t       exp_q[$];
    int         addr_q[$];
    logic [7:0] mem [0:63];
    int  checks = 0, errors = 0;
    bit  ce_all = 1'b1, chk_en = 1'b0;
    int  lat = 1, valid_cnt = 0, rd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_run(input bit l, input int n);
        run_t e;
        if (exp_q.size() > 0 && exp_q[$].lvl == l) begin
            e = exp_q.pop_back();
            e.len += n;
        end else begin
            e.lvl = l;
            e.len = n;
        end
        exp_q.push_back(e);
    endtask

    task automatic emit(input bit l, input int n);
        run_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wave_extra: run lvl=%0d len=%0d, required no run", l, n);
        end else begin
            e = exp_q.pop_front();
            if (e.lvl != l || e.len != n) begin
                errors++;
                $display("FAIL wave_run: lvl=%0d len=%0d, required lvl=%0d len=%0d", l, n, e.lvl, e.len);
            end
        end
    endtask

    // expected tape as high/low runs in ce ticks; the last bit's low merges into the tail
    task automatic prep(input int size, input int latency, input bit allce);
        exp_q.delete();
        addr_q.delete();
        lat    = latency;
        ce_all = allce;
        rd_cnt = 0;
        for (int c = 0; c < PC; c++) begin
            push_run(1'b1, PH);
            push_run(1'b0, PH);
        end
        push_run(1'b1, SH);
        push_run(1'b0, SH);
        for (int b = 0; b < size; b++) begin
            addr_q.push_back(b);
            for (int k = 7; k >= 0; k--) begin
                push_run(1'b1, mem[b][k] ? OH : ZH);
                push_run(1'b0, mem[b][k] ? OH : ZH);
            end
        end
        push_run(1'b0, TT);
    endtask

    task automatic go(input int size);
        @(posedge clk); #1;
        tap_size  = AW'(size);
        tap_ready = 1'b1;
        play      = 1'b1;
        chk_en    = 1'b1;
    endtask

    task automatic finish_run(input int size);
        int lim = 0;
        while (!done && lim < 20000) begin
            @(negedge clk);
            lim++;
        end
        @(negedge clk);
        chk("done_seen", done, 1);
        chk("active_end", active, 0);
        chk("ear_end", ear, 0);
        chk("rd_count", rd_cnt, size);
        chk("wave_left", exp_q.size(), 0);
        @(posedge clk); #1;
        chk_en = 1'b0;
        play   = 1'b0;
        rewind = 1'b1;
        @(posedge clk); #1;
        rewind = 1'b0;
        @(negedge clk);
        chk("rewind_done", done, 0);
        chk("rewind_active", active, 0);
    endtask

    task automatic fill_random(input int size);
        for (int b = 0; b < size; b++) mem[b] = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_valid();
        int lim = 0;
        while (!mem_valid && lim < 5000) begin
            @(negedge clk);
            lim++;
        end
        chk("valid_seen", mem_valid, 1);
    endtask

    initial forever begin
        @(posedge clk); #1;
        ce = ce_all ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    // memory with programmable latency; checks read pulses and address order
    initial begin
        int pend = 0;
        logic [7:0] pdata = '0;
        bit prev_rd = 1'b0;
        int ea;
        forever begin
            @(posedge clk); #1;
            mem_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = pdata;
                    valid_cnt++;
                end
            end
            if (mem_rd) begin
                rd_cnt++;
                chk("rd_pulse_width", {31'd0, prev_rd}, 0);
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr: read at %0d, required no read", mem_addr);
                end else begin
                    ea = addr_q.pop_front();
                    if (mem_addr != AW'(ea)) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d, required %0d", mem_addr, ea);
                    end
                end
                pend  = lat;
                pdata = mem[mem_addr[5:0]];
            end
            prev_rd = mem_rd;
        end
    end

    // run-length monitor; ticks during a fetch or a pause do not advance the tape
    initial begin
        bit trk = 1'b0, lvl = 1'b0, fetching = 1'b0;
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                trk      = 1'b0;
                fetching = 1'b0;
            end else begin
                if (mem_rd) fetching = 1'b1;
                if (chk_en && active) begin
                    if (!trk) begin
                        trk = 1'b1;
                        lvl = ear;
                        cnt = 0;
                    end else if (ear != lvl) begin
                        emit(lvl, cnt);
                        lvl = ear;
                        cnt = 0;
                    end
                    if (ce && play && !fetching) cnt++;
                end else if (trk) begin
                    if (chk_en) emit(lvl, cnt);
                    trk = 1'b0;
                end
                if (mem_valid) fetching = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int size, n0;
        bit held;
        logic e0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ear", ear, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single byte A5, ce every cycle
        mem[0] = 8'hA5;
        prep(1, 1, 1'b1);
        go(1);
        finish_run(1);

        // same random image at latency 1 and 7
        size = int'($urandom_range(2, 4));
        fill_random(size);
        prep(size, 1, 1'b0);
        go(size);
        finish_run(size);
        prep(size, 7, 1'b0);
        go(size);
        finish_run(size);

        for (int it = 0; it < 3; it++) begin
            size = int'($urandom_range(1, 5));
            fill_random(size);
            prep(size, int'($urandom_range(1, 9)), 1'($urandom_range(0, 1)));
            go(size);
            finish_run(size);
        end

        // pause mid-bit
        fill_random(2);
        prep(2, 3, 1'b0);
        go(2);
        wait_valid();
        repeat (4) @(posedge clk);
        #1 play = 1'b0;
        @(negedge clk);
        e0   = ear;
        held = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (ear !== e0) held = 1'b0;
        end
        chk("pause_hold", {31'd0, held}, 1);
        @(posedge clk); #1;
        play = 1'b1;
        finish_run(2);

        // rewind during WAITD, stale completion three cycles later
        fill_random(2);
        prep(2, 6, 1'b1);
        go(2);
        n0 = 0;
        while (!mem_rd && n0 < 5000) begin
            @(negedge clk);
            n0++;
        end
        chk("rd_seen", mem_rd, 1);
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        play   = 1'b0;
        rewind = 1'b1;
        @(posedge clk); #1;
        rewind = 1'b0;
        @(negedge clk);
        chk("rwd_active", active, 0);
        chk("rwd_ear", ear, 0);
        n0 = rd_cnt;
        repeat (6) @(negedge clk);
        chk("stale_active", active, 0);
        chk("stale_no_rd", rd_cnt, n0);
        prep(2, 2, 1'b1);
        go(2);
        finish_run(2);

        // tap_size zero never starts
        prep(0, 1, 1'b1);
        @(posedge clk); #1;
        tap_size = '0;
        play     = 1'b1;
        repeat (30) @(negedge clk);
        chk("size0_active", active, 0);
        chk("size0_done", done, 0);
        chk("size0_rd", rd_cnt, 0);
        @(posedge clk); #1;
        play = 1'b0;

        // tap_ready dropped mid-bits
        fill_random(2);
        prep(2, 2, 1'b0);
        go(2);
        wait_valid();
        repeat (3) @(posedge clk);
        #1;
        chk_en    = 1'b0;
        tap_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("drop_active", active, 0);
        chk("drop_ear", ear, 0);
        play = 1'b0;
        @(posedge clk); #1;
        tap_ready = 1'b1;

        // async reset mid-leader
        fill_random(2);
        prep(2, 1, 1'b1);
        go(2);
        repeat (20) @(posedge clk);
        #1 chk_en = 1'b0;
        @(negedge clk);
        chk("leader_active", active, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ear", ear, 0);
        chk("arst_mem_rd", mem_rd, 0);
        chk("arst_active", active, 0);
        play = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
